// File: rtl/tagger_cfg_ctrl.sv
// Tagger partition-table programmer: turns one update command into register-bus writes.
// Define TAGGER_CFG_CTRL_READBACK_EN to add a read-back verification pass.
module tagger_cfg_ctrl #(
    parameter int          ADDR_WIDTH   = 64,
    parameter int          MAXPARTITION = 16,
    parameter int          PATID_LEN    = 8,
    parameter logic [31:0] REG_BASE     = 32'h0
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic [$clog2(MAXPARTITION):0]   cmd_idx_i,
    input  logic [ADDR_WIDTH-1:0]           cmd_addr_i,
    input  logic [PATID_LEN-1:0]            cmd_patid_i,
    input  logic [1:0]                      cmd_conf_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o,
    output logic                            reg_valid_o,
    output logic                            reg_write_o,
    output logic [31:0]                     reg_addr_o,
    output logic [31:0]                     reg_wdata_o,
    output logic [3:0]                      reg_wstrb_o,
    input  logic                            reg_ready_i,
    input  logic [31:0]                     reg_rdata_i,
    input  logic                            reg_error_i
);

    localparam int IW = $clog2(MAXPARTITION) + 1;

`ifdef TAGGER_CFG_CTRL_READBACK_EN
    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_WRITE, S_READ, S_RESP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_WRITE, S_RESP
    } state_t;
`endif

    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [PATID_LEN-1:0]  r_patid;
    logic [1:0]            r_conf;
    logic [1:0]            r_beat;
    logic                  r_last;
    logic                  r_done;
    logic                  r_err;
    logic                  r_reg_valid;
    logic                  r_reg_write;
    logic [31:0]           r_reg_addr;
    logic [31:0]           r_reg_wdata;
    logic [3:0]            r_reg_wstrb;

    logic [63:0] w_addr_ext;
    logic [31:0] w_beat_addr;
    logic [31:0] w_beat_data;
    logic        w_idx_bad;

    assign w_addr_ext  = 64'(r_addr);
    assign w_beat_addr = REG_BASE + (32'(r_idx) << 4) + {28'd0, r_beat, 2'b00};
    assign w_idx_bad   = 32'(r_idx) >= 32'(MAXPARTITION);

    always_comb begin
        w_beat_data = '0;
        unique case (r_beat)
            2'd0:    w_beat_data = w_addr_ext[31:0];
            2'd1:    w_beat_data = w_addr_ext[63:32];
            2'd2:    w_beat_data = 32'(r_patid);
            default: w_beat_data = {30'd0, r_conf};
        endcase
    end

`ifdef TAGGER_CFG_CTRL_READBACK_EN
    localparam logic [63:0] HI_MASK  = (64'd1 << (ADDR_WIDTH - 32)) - 64'd1;
    localparam logic [63:0] PID_MASK = (64'd1 << PATID_LEN) - 64'd1;

    logic [31:0] w_mask;
    logic        w_rd_bad;

    // Unimplemented upper bits may read back as anything.
    always_comb begin
        w_mask = '0;
        unique case (r_beat)
            2'd0:    w_mask = 32'hFFFF_FFFF;
            2'd1:    w_mask = HI_MASK[31:0];
            2'd2:    w_mask = PID_MASK[31:0];
            default: w_mask = 32'h0000_0003;
        endcase
    end

    assign w_rd_bad = reg_error_i || ((reg_rdata_i & w_mask) != w_beat_data);
`else
    logic w_unused;
    assign w_unused = ^reg_rdata_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_addr      <= '0;
            r_patid     <= '0;
            r_conf      <= '0;
            r_beat      <= '0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_reg_valid <= 1'b0;
            r_reg_write <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_wstrb <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_idx   <= cmd_idx_i;
                        r_addr  <= cmd_addr_i;
                        r_patid <= cmd_patid_i;
                        r_conf  <= cmd_conf_i;
                        r_beat  <= '0;
                        r_last  <= 1'b0;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_idx_bad) begin
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_state     <= S_WRITE;
                        r_reg_valid <= 1'b1;
                        r_reg_write <= 1'b1;
                        r_reg_addr  <= w_beat_addr;
                        r_reg_wdata <= w_beat_data;
                        r_reg_wstrb <= 4'hF;
                    end
                end
                S_WRITE: begin
                    if (r_reg_valid) begin
                        if (reg_ready_i) begin
                            r_reg_valid <= 1'b0;
                            r_reg_write <= 1'b0;
                            r_reg_addr  <= '0;
                            r_reg_wdata <= '0;
                            r_reg_wstrb <= '0;
                            if (reg_error_i) begin
                                r_err   <= 1'b1;
                                r_state <= S_RESP;
                            end else begin
                                r_beat <= r_beat + 2'd1;
                                r_last <= (r_beat == 2'd3);
                            end
                        end
                    end else if (r_last) begin
                        r_last <= 1'b0;
`ifdef TAGGER_CFG_CTRL_READBACK_EN
                        r_state     <= S_READ;
                        r_reg_valid <= 1'b1;
                        r_reg_addr  <= w_beat_addr;
`else
                        r_done  <= 1'b1;
                        r_state <= S_RESP;
`endif
                    end else begin
                        r_reg_valid <= 1'b1;
                        r_reg_write <= 1'b1;
                        r_reg_addr  <= w_beat_addr;
                        r_reg_wdata <= w_beat_data;
                        r_reg_wstrb <= 4'hF;
                    end
                end
`ifdef TAGGER_CFG_CTRL_READBACK_EN
                S_READ: begin
                    if (r_reg_valid) begin
                        if (reg_ready_i) begin
                            r_reg_valid <= 1'b0;
                            r_reg_addr  <= '0;
                            if (w_rd_bad) begin
                                r_err   <= 1'b1;
                                r_state <= S_RESP;
                            end else begin
                                r_beat <= r_beat + 2'd1;
                                r_last <= (r_beat == 2'd3);
                            end
                        end
                    end else if (r_last) begin
                        r_last  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_reg_valid <= 1'b1;
                        r_reg_addr  <= w_beat_addr;
                    end
                end
`endif
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready_o = (r_state == S_IDLE);
    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign reg_valid_o = r_reg_valid;
    assign reg_write_o = r_reg_write;
    assign reg_addr_o  = r_reg_addr;
    assign reg_wdata_o = r_reg_wdata;
    assign reg_wstrb_o = r_reg_wstrb;

endmodule

// File: tb/tb_tagger_cfg_ctrl.sv
// Scoreboard bench for tagger_cfg_ctrl: expected bus beats and done/err pulses
// are queued by the stimulus and retired by an independent monitor.
module tb_tagger_cfg_ctrl;

    localparam int K_BEAT = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
        int          cyc;
    } ev_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [4:0]  cmd_idx_i = '0;
    logic [63:0] cmd_addr_i = '0;
    logic [7:0]  cmd_patid_i = '0;
    logic [1:0]  cmd_conf_i = '0;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        reg_valid_o;
    logic        reg_write_o;
    logic [31:0] reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic [3:0]  reg_wstrb_o;
    logic        reg_ready_i = 1'b1;
    logic [31:0] reg_rdata_i = '0;
    logic        reg_error_i = 1'b0;

    ev_t         q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          stall_left = 0;
    logic [3:0]  stall_off = 4'h0;
    logic [3:0]  err_off = 4'h0;
    bit          err_arm = 0;
    bit          corrupt = 0;
    logic [31:0] mem [logic [31:0]];

    tagger_cfg_ctrl dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_idx_i   (cmd_idx_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_patid_i (cmd_patid_i),
        .cmd_conf_i  (cmd_conf_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .reg_valid_o (reg_valid_o),
        .reg_write_o (reg_write_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_wstrb_o (reg_wstrb_o),
        .reg_ready_i (reg_ready_i),
        .reg_rdata_i (reg_rdata_i),
        .reg_error_i (reg_error_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc = cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic expect_ev(int kind, logic [31:0] a, logic [31:0] d,
                             logic wr, int c);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        e.wr   = wr;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic exp_writes(logic [31:0] b, logic [31:0] d0, logic [31:0] d1,
                              logic [31:0] d2, logic [31:0] d3,
                              int c0, int c1, int c2, int c3);
        expect_ev(K_BEAT, b,         d0, 1'b1, c0);
        expect_ev(K_BEAT, b + 32'h4, d1, 1'b1, c1);
        expect_ev(K_BEAT, b + 32'h8, d2, 1'b1, c2);
        expect_ev(K_BEAT, b + 32'hC, d3, 1'b1, c3);
    endtask

    task automatic exp_reads(logic [31:0] b, int c, int n);
        for (int i = 0; i < n; i++)
            expect_ev(K_BEAT, b + 32'(4 * i), 32'h0, 1'b0, c + 2 * i);
    endtask

    task automatic check_ev(int kind);
        ev_t e;
        int  rel;
        bit  bad;
        checks++;
        rel = cyc - t0;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d addr=%h cyc=%0d (none expected)",
                     kind, reg_addr_o, rel);
            return;
        end
        e = q.pop_front();
        bad = (e.kind != kind) || (rel != e.cyc);
        if (kind == K_BEAT && e.kind == K_BEAT) begin
            if (reg_addr_o != e.addr || reg_write_o != e.wr) bad = 1;
            if (reg_wstrb_o != (e.wr ? 4'hF : 4'h0)) bad = 1;
            if (e.wr && reg_wdata_o != e.data) bad = 1;
        end
        if (bad) begin
            errors++;
            $display("FAIL event got kind=%0d addr=%h wr=%b data=%h strb=%h cyc=%0d expected kind=%0d addr=%h wr=%b data=%h cyc=%0d",
                     kind, reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o, rel,
                     e.kind, e.addr, e.wr, e.data, e.cyc);
        end
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_ready"}, 32'(cmd_ready_o), 32'd1);
        chk({tag, "_busy"},  32'(busy_o),      32'd0);
        chk({tag, "_done"},  32'(done_o),      32'd0);
        chk({tag, "_err"},   32'(err_o),       32'd0);
        chk({tag, "_valid"}, 32'(reg_valid_o), 32'd0);
        chk({tag, "_write"}, 32'(reg_write_o), 32'd0);
        chk({tag, "_addr"},  reg_addr_o,       32'd0);
        chk({tag, "_wdata"}, reg_wdata_o,      32'd0);
        chk({tag, "_wstrb"}, 32'(reg_wstrb_o), 32'd0);
    endtask

    // Monitor: retires queued expectations as the DUT presents them.
    logic        stl = 1'b0;
    logic [31:0] h_addr = '0;
    logic [31:0] h_data = '0;
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            stl = 1'b0;
        end else begin
            if (cmd_valid_i && cmd_ready_o) t0 = cyc;
            if (stl) begin
                checks++;
                if (!reg_valid_o || reg_addr_o != h_addr || reg_wdata_o != h_data) begin
                    errors++;
                    $display("FAIL stall_hold valid=%b addr=%h data=%h expected addr=%h data=%h",
                             reg_valid_o, reg_addr_o, reg_wdata_o, h_addr, h_data);
                end
            end
            stl    = reg_valid_o && !reg_ready_i;
            h_addr = reg_addr_o;
            h_data = reg_wdata_o;
            if (reg_valid_o && reg_ready_i) check_ev(K_BEAT);
            if (done_o) check_ev(K_DONE);
            if (err_o) check_ev(K_ERR);
        end
    end

    // Bus responder with optional stall, error and read corruption.
    always @(posedge clk_i) begin
        #1;
        reg_ready_i = 1'b1;
        reg_error_i = 1'b0;
        reg_rdata_i = '0;
        if (reg_valid_o) begin
            if (stall_left > 0 && reg_addr_o[3:0] == stall_off) begin
                reg_ready_i = 1'b0;
                stall_left--;
            end
            if (reg_write_o) begin
                mem[reg_addr_o] = reg_wdata_o;
            end else begin
                reg_rdata_i = mem.exists(reg_addr_o) ? mem[reg_addr_o] : 32'h0;
                if (corrupt && reg_addr_o[3:0] == 4'h8) reg_rdata_i = 32'h6;
            end
            if (err_arm && reg_ready_i && reg_addr_o[3:0] == err_off) begin
                reg_error_i = 1'b1;
                err_arm = 0;
            end
        end
    end

    task automatic send(logic [4:0] idx, logic [63:0] a, logic [7:0] p, logic [1:0] c);
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b1;
        cmd_idx_i   = idx;
        cmd_addr_i  = a;
        cmd_patid_i = p;
        cmd_conf_i  = c;
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle(int limit);
        int n = 0;
        while ((q.size() != 0 || busy_o) && n < limit) begin
            @(posedge clk_i);
            n++;
        end
        if (n >= limit) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d busy=%b required pending=0", q.size(), busy_o);
            q.delete();
        end
        repeat (3) @(posedge clk_i);
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk_reset("rst");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Nominal update of partition 3, zero-wait bus.
        exp_writes(32'h30, 32'h8000_0000, 32'h1, 32'h5, 32'h1, 2, 4, 6, 8);
`ifdef TAGGER_CFG_CTRL_READBACK_EN
        exp_reads(32'h30, 10, 4);
        expect_ev(K_DONE, 0, 0, 0, 18);
`else
        expect_ev(K_DONE, 0, 0, 0, 10);
`endif
        send(5'd3, 64'h0000_0001_8000_0000, 8'h05, 2'b01);
        repeat (3) @(posedge clk_i);
        #1;
        chk("busy_mid", 32'(busy_o), 32'd1);
        chk("ready_mid", 32'(cmd_ready_o), 32'd0);
        cmd_valid_i = 1'b1;
        cmd_idx_i   = 5'd0;
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        wait_idle(80);

        // Out-of-range index: rejected without bus traffic.
        expect_ev(K_ERR, 0, 0, 0, 2);
        send(5'd16, 64'h1234, 8'h11, 2'b10);
        @(posedge clk_i);
        #1;
        chk("busy_reject", 32'(busy_o), 32'd1);
        @(posedge clk_i);
        #1;
        chk("ready_after_reject", 32'(cmd_ready_o), 32'd1);
        wait_idle(40);

        // Five wait states on the PATID beat.
        stall_off  = 4'h8;
        stall_left = 5;
        exp_writes(32'h10, 32'hCDEF_0123, 32'hAB, 32'hFF, 32'h3, 2, 4, 11, 13);
`ifdef TAGGER_CFG_CTRL_READBACK_EN
        exp_reads(32'h10, 15, 4);
        expect_ev(K_DONE, 0, 0, 0, 23);
`else
        expect_ev(K_DONE, 0, 0, 0, 15);
`endif
        send(5'd1, 64'h0000_00AB_CDEF_0123, 8'hFF, 2'b11);
        wait_idle(80);
        chk("stall_consumed", 32'(stall_left), 32'd0);

        // Bus error on ADDR_HI aborts the remaining beats.
        err_off = 4'h4;
        err_arm = 1;
        expect_ev(K_BEAT, 32'h50, 32'h10, 1'b1, 2);
        expect_ev(K_BEAT, 32'h54, 32'h2,  1'b1, 4);
        expect_ev(K_ERR, 0, 0, 0, 5);
        send(5'd5, 64'h0000_0002_0000_0010, 8'h33, 2'b11);
        wait_idle(60);

        // Reset asserted while the PATID beat is on the bus.
        expect_ev(K_BEAT, 32'h70, 32'h1234_5678, 1'b1, 2);
        expect_ev(K_BEAT, 32'h74, 32'h9,         1'b1, 4);
        send(5'd7, 64'h0000_0009_1234_5678, 8'h7E, 2'b00);
        repeat (5) @(posedge clk_i);
        #2;
        chk("pre_rst_valid", 32'(reg_valid_o), 32'd1);
        chk("pre_rst_addr", reg_addr_o, 32'h78);
        chk("pre_rst_pending", 32'(q.size()), 32'd0);
        rst_ni = 1'b0;
        #1;
        chk_reset("mid_rst");
        q.delete();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Normal sequence after the reset.
        exp_writes(32'h00, 32'h0000_1234, 32'hDEAD_BEEF, 32'hA5, 32'h2, 2, 4, 6, 8);
`ifdef TAGGER_CFG_CTRL_READBACK_EN
        exp_reads(32'h00, 10, 4);
        expect_ev(K_DONE, 0, 0, 0, 18);
`else
        expect_ev(K_DONE, 0, 0, 0, 10);
`endif
        send(5'd0, 64'hDEAD_BEEF_0000_1234, 8'hA5, 2'b10);
        wait_idle(80);

`ifdef TAGGER_CFG_CTRL_READBACK_EN
        // PATID reads back as 0x06: abort before the CONF read.
        corrupt = 1;
        exp_writes(32'h20, 32'h100, 32'h0, 32'h5, 32'h1, 2, 4, 6, 8);
        exp_reads(32'h20, 10, 3);
        expect_ev(K_ERR, 0, 0, 0, 15);
        send(5'd2, 64'h0000_0000_0000_0100, 8'h05, 2'b01);
        wait_idle(80);
        corrupt = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tagger_cfg_ctrl.md
TAGGER_CFG_CTRL -- requirements
Module: tagger_cfg_ctrl

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, default 64, partition boundary width (legal 32..64).
- MAXPARTITION, default 16, number of partition table entries.
- PATID_LEN, default 8, PatID width (legal 1..32).
- REG_BASE, default 32'h0, byte base address of the tagger register file.

REQ-002 Ports SHALL be:
- clk_i  in  1  clock; one clock, all logic on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- cmd_valid_i  in  1  partition update request.
- cmd_ready_o  out  1  request accepted when high with cmd_valid_i.
- cmd_idx_i  in  $clog2(MAXPARTITION)+1  target partition index.
- cmd_addr_i  in  ADDR_WIDTH  partition upper boundary.
- cmd_patid_i  in  PATID_LEN  PatID for the partition.
- cmd_conf_i  in  2  partition mode.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse: sequence completed without error.
- err_o  out  1  one-cycle pulse: sequence aborted or rejected.
- reg_valid_o  out  1  register bus request valid.
- reg_write_o  out  1  1 = write, 0 = read.
- reg_addr_o  out  32  register byte address.
- reg_wdata_o  out  32  write data.
- reg_wstrb_o  out  4  write strobes; always 4'hF on writes, 4'h0 on reads.
- reg_ready_i  in  1  register bus beat completes when high with reg_valid_o.
- reg_rdata_i  in  32  read data, valid in the completing cycle.
- reg_error_i  in  1  bus error, valid in the completing cycle.

Function
REQ-003 Partition i register map SHALL be (offsets from REG_BASE + 16*i):
- +0x0 ADDR_LO = addr[31:0].
- +0x4 ADDR_HI = addr[ADDR_WIDTH-1:32], zero-extended; 0 when ADDR_WIDTH = 32.
- +0x8 PATID = patid, zero-extended.
- +0xC CONF = {30'b0, conf}.

REQ-004 FSM states SHALL be IDLE, CHECK, WRITE, READ, RESP.

REQ-005 cmd_ready_o SHALL equal (state == IDLE); accepting a command captures idx, addr, patid and conf into internal registers and moves to CHECK.

REQ-006 CHECK SHALL last one cycle:
- If idx >= MAXPARTITION, go to RESP with error and issue no bus traffic.
- Otherwise go to WRITE with beat counter 0.

REQ-007 WRITE SHALL issue four writes in the order ADDR_LO, ADDR_HI, PATID, CONF; CONF is always last because it commits the entry.

REQ-008 All reg_* outputs SHALL be registered and held stable while reg_valid_o is high and reg_ready_i is low.
- reg_valid_o deasserts for exactly one cycle between beats.
- Minimum beat-to-beat spacing is 2 cycles.

REQ-009 reg_error_i sampled high at beat completion SHALL abort all remaining beats and move to RESP with error.

REQ-010 RESP SHALL last one cycle and pulse exactly one of done_o or err_o, then return to IDLE.

REQ-011 busy_o SHALL be high in every state except IDLE.

REQ-012 Timing with zero-wait-state bus: command accepted in cycle 0; first reg_valid_o in cycle 2; done_o in cycle 10.

REQ-013 cmd_valid_i while busy SHALL be ignored and not captured.

Reset
REQ-014 While rst_ni is low, outputs SHALL be: state IDLE; cmd_ready_o = 1; busy_o, done_o, err_o, reg_valid_o, reg_write_o = 0; reg_addr_o, reg_wdata_o, reg_wstrb_o = 0.

REQ-015 Reset asserted mid-sequence SHALL drop reg_valid_o immediately (asynchronously), pulse neither done_o nor err_o, and leave the partially written entry as is.

Configuration
REQ-016 Macro TAGGER_CFG_CTRL_READBACK_EN controls readback verification.
- Defined: after WRITE, READ SHALL read all four registers in the same order. A read mismatch against the written value (ADDR_HI/PATID/CONF compared on implemented bits only), or a read error, aborts to RESP with err_o. The zero-wait done_o moves to cycle 18.
- Undefined: the READ state and its logic are absent; WRITE goes directly to RESP.

Verification
REQ-017 Bench SHALL cover these directed scenarios:
- idx=3, addr=64'h0000_0001_8000_0000, patid=8'h05, conf=2'b01, ready always 1 -> writes 0x30=8000_0000, 0x34=0000_0001, 0x38=0000_0005, 0x3C=0000_0001; done_o in cycle 10.
- idx=16 with MAXPARTITION=16 -> no reg_valid_o; err_o pulse in cycle 2; cmd_ready_o high in cycle 3.
- reg_ready_i held low 5 cycles on the PATID beat -> reg_addr_o and reg_wdata_o stable throughout; CONF issued after; done_o delayed by 5 cycles.
- reg_error_i on the ADDR_HI beat -> PATID and CONF never issued; err_o pulse; done_o stays 0.
- rst_ni low during the third beat -> reg_valid_o low the same cycle; all outputs at reset values; next command after reset completes normally.
- READBACK_EN defined, readback of PATID returns 0x06 after write 0x05 -> err_o pulse; CONF read not issued.
